// File: rtl/wb_snoop_pkg.sv
// Shared definitions for the snooping Wishbone initiator stage.
//   state_e      : FSM encoding of wb_snoop_initiator (also exported on its
//                  debug state port)
//   CTI_CLASSIC  : cycle type driven towards RAM (every beat is a single access)
//   BTE_LINEAR   : burst type driven towards RAM
package wb_snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_MEM   = 2'd2
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_snoop_initiator_collector.sv
// snoop_ack_collector: gathers per-core snoop acknowledges for one snoop.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        start of a new snoop: zero ack mask, hit accumulator, timer
//   active_i       high on every SNOOP cycle
//   snoop_ack_i    per-core acknowledge
//   snoop_hit_i    per-core hit, only meaningful together with the ack
//   done_o         this SNOOP cycle is the last one (all acked or timer expired)
//   timeout_o      the snoop ends this cycle because of the timer alone
//   hit_o          hits collected so far, including this cycle's acks
module snoop_ack_collector #(
  parameter int NUM_CORES     = 1,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 active_i,
  input  logic [NUM_CORES-1:0] snoop_ack_i,
  input  logic [NUM_CORES-1:0] snoop_hit_i,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [NUM_CORES-1:0] hit_o
);

  localparam int TW = $clog2(SNOOP_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(SNOOP_TIMEOUT - 1);

  logic [NUM_CORES-1:0] ack_mask_q, ack_mask_d;
  logic [NUM_CORES-1:0] hit_acc_q, hit_acc_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic [NUM_CORES-1:0] ack_now;
  logic [NUM_CORES-1:0] hit_now;
  logic                 all_acked;
  logic                 last_cycle;

  always_comb begin
    // Include this cycle's acks so that acks arriving in the first SNOOP
    // cycle finish the snoop in that same cycle.
    ack_now    = ack_mask_q | snoop_ack_i;
    hit_now    = hit_acc_q | (snoop_hit_i & snoop_ack_i);
    all_acked  = &ack_now;
    last_cycle = (timer_q == LAST);

    done_o    = active_i & (all_acked | last_cycle);
    // All-acked wins over an expiring timer.
    timeout_o = active_i & last_cycle & ~all_acked;
    hit_o     = hit_now;

    ack_mask_d = ack_mask_q;
    hit_acc_d  = hit_acc_q;
    timer_d    = timer_q;
    if (clear_i) begin
      ack_mask_d = '0;
      hit_acc_d  = '0;
      timer_d    = '0;
    end else if (active_i) begin
      ack_mask_d = ack_now;
      hit_acc_d  = hit_now;
      timer_d    = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_mask_q <= '0;
      hit_acc_q  <= '0;
      timer_q    <= '0;
    end else begin
      ack_mask_q <= ack_mask_d;
      hit_acc_q  <= hit_acc_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: rtl/wb_snoop_initiator.sv
// wb_snoop_initiator: Wishbone pass-through between the interconnect memory
// port (wb_s_*) and main RAM (wb_m_*). Each write beat is first broadcast as
// an invalidate snoop to all cores and forwarded to RAM only once every core
// has acknowledged or the snoop timer expired. Reads go straight to RAM.
//
// Handshake: a beat is requested while wb_s_cyc_i & wb_s_stb_i are high and
// completes in the cycle where exactly one of ack/err/rty is returned; the
// RAM side follows the same rule, one beat per request (bursts are split).
// Snoop handshake: snoop_req_o is a level held for the whole snoop; a core
// answers with a snoop_ack_i pulse (repeats are harmless), snoop_hit_i is
// sampled only together with that core's ack.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   wb_s_*                       Wishbone target port from the interconnect
//   wb_m_*                       Wishbone initiator port to RAM (classic cycles)
//   snoop_adr_o                  snoop address, replicated per core
//   snoop_req_o                  snoop request level
//   snoop_ack_i, snoop_hit_i     per-core snoop response
//   snoop_hit_mask_o             hits of the last completed snoop
//   snoop_timeout_o              sticky: some snoop ended by timeout
//   dbg_state_o                  current FSM state
module wb_snoop_initiator
  import wb_snoop_pkg::*;
#(
  parameter int NUM_CORES     = 1,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [31:0]             wb_s_adr_i,
  input  logic [31:0]             wb_s_dat_i,
  input  logic [3:0]              wb_s_sel_i,
  input  logic                    wb_s_we_i,
  input  logic                    wb_s_cyc_i,
  input  logic                    wb_s_stb_i,
  input  logic [2:0]              wb_s_cti_i,
  input  logic [1:0]              wb_s_bte_i,
  output logic [31:0]             wb_s_dat_o,
  output logic                    wb_s_ack_o,
  output logic                    wb_s_err_o,
  output logic                    wb_s_rty_o,
  output logic [31:0]             wb_m_adr_o,
  output logic [31:0]             wb_m_dat_o,
  output logic [3:0]              wb_m_sel_o,
  output logic                    wb_m_we_o,
  output logic                    wb_m_cyc_o,
  output logic                    wb_m_stb_o,
  output logic [2:0]              wb_m_cti_o,
  output logic [1:0]              wb_m_bte_o,
  input  logic [31:0]             wb_m_dat_i,
  input  logic                    wb_m_ack_i,
  input  logic                    wb_m_err_i,
  input  logic                    wb_m_rty_i,
  output logic [32*NUM_CORES-1:0] snoop_adr_o,
  output logic                    snoop_req_o,
  input  logic [NUM_CORES-1:0]    snoop_ack_i,
  input  logic [NUM_CORES-1:0]    snoop_hit_i,
  output logic [NUM_CORES-1:0]    snoop_hit_mask_o,
  output logic                    snoop_timeout_o,
  output state_e                  dbg_state_o
);

  state_e               state_q, state_d;
  logic [31:0]          snoop_adr_q, snoop_adr_d;
  logic [NUM_CORES-1:0] hit_mask_q, hit_mask_d;
  logic                 timeout_q, timeout_d;

  logic                 coll_clear;
  logic                 coll_active;
  logic                 coll_done;
  logic                 coll_timeout;
  logic [NUM_CORES-1:0] coll_hit;

  logic                 req_valid;
  logic                 unused_burst_info;

  // Burst qualifiers are accepted but meaningless once beats are split.
  assign unused_burst_info = ^{wb_s_cti_i, wb_s_bte_i};

  snoop_ack_collector #(
    .NUM_CORES     (NUM_CORES),
    .SNOOP_TIMEOUT (SNOOP_TIMEOUT)
  ) u_collector (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .clear_i     (coll_clear),
    .active_i    (coll_active),
    .snoop_ack_i (snoop_ack_i),
    .snoop_hit_i (snoop_hit_i),
    .done_o      (coll_done),
    .timeout_o   (coll_timeout),
    .hit_o       (coll_hit)
  );

  // Address/data/select/we are pure pass-through; only cyc/stb are gated.
  assign wb_m_adr_o  = wb_s_adr_i;
  assign wb_m_dat_o  = wb_s_dat_i;
  assign wb_m_sel_o  = wb_s_sel_i;
  assign wb_m_we_o   = wb_s_we_i;
  assign wb_m_cti_o  = CTI_CLASSIC;
  assign wb_m_bte_o  = BTE_LINEAR;
  assign wb_s_dat_o  = wb_m_dat_i;

  assign snoop_adr_o      = {NUM_CORES{snoop_adr_q}};
  assign snoop_req_o      = (state_q == ST_SNOOP);
  assign snoop_hit_mask_o = hit_mask_q;
  assign snoop_timeout_o  = timeout_q;
  assign dbg_state_o      = state_q;

  assign req_valid = wb_s_cyc_i & wb_s_stb_i;

  always_comb begin
    state_d     = state_q;
    snoop_adr_d = snoop_adr_q;
    hit_mask_d  = hit_mask_q;
    timeout_d   = timeout_q;
    coll_clear  = 1'b0;
    coll_active = 1'b0;
    wb_m_cyc_o  = 1'b0;
    wb_m_stb_o  = 1'b0;
    wb_s_ack_o  = 1'b0;
    wb_s_err_o  = 1'b0;
    wb_s_rty_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (wb_s_we_i) begin
            snoop_adr_d = wb_s_adr_i;
            coll_clear  = 1'b1;
            state_d     = ST_SNOOP;
          end else begin
            state_d = ST_MEM;
          end
        end
      end

      ST_SNOOP: begin
        coll_active = 1'b1;
        if (coll_done) begin
          hit_mask_d = coll_hit;
          if (coll_timeout) begin
            timeout_d = 1'b1;
          end
          // An abandoned write still finishes its snoop; the extra
          // invalidate is harmless.
          state_d = wb_s_cyc_i ? ST_MEM : ST_IDLE;
        end
      end

      ST_MEM: begin
        wb_m_cyc_o = req_valid;
        wb_m_stb_o = req_valid;
        wb_s_ack_o = wb_m_ack_i;
        wb_s_err_o = wb_m_err_i;
        wb_s_rty_o = wb_m_rty_i;
        if (wb_m_ack_i || wb_m_err_i || wb_m_rty_i || !wb_s_cyc_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      snoop_adr_q <= '0;
      hit_mask_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snoop_adr_q <= snoop_adr_d;
      hit_mask_q  <= hit_mask_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule
